// File: rtl/game_pkg.sv
// game_pkg: player/enemy shared types, sprite geometry and the attack animation offset lookup.
package game_pkg;
    typedef enum logic [1:0] {IDLE, WINDUP, STRIKE, RECOVER} attack_state_t;
    localparam int          SPRITE_W     = 60;
    localparam int          SPRITE_H     = 54;
    localparam logic [15:0] SPRITE_WORDS = 16'(SPRITE_W * SPRITE_H);
    // Wind-up and recovery share the middle frame; only the strike uses the last one.
    function automatic logic [15:0] anim_offset_of(attack_state_t s, logic [15:0] base, logic [15:0] words);
        return (s == STRIKE) ? base + (words << 1) : (s == IDLE) ? base : base + words;
    endfunction
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-Clk tick per rising edge of frame_clk.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);
    logic fc_q, fc_d, tick_q, tick_d;
    always_comb begin
        fc_d   = frame_clk;
        tick_d = frame_clk & ~fc_q;
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fc_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            fc_q   <= fc_d;
            tick_q <= tick_d;
        end
    end
    assign tick = tick_q;
endmodule

// File: rtl/melee_attack_ctrl.sv
// melee_attack_ctrl: frame-timed wind-up/strike/recover sequencer driving the player hit signal.
// Define ATTACK_BUFFER_EN to let a press made during RECOVER chain straight into the next wind-up.
module melee_attack_ctrl
    import game_pkg::*;
#(
    parameter int          WINDUP_FRAMES  = 4,
    parameter int          STRIKE_FRAMES  = 3,
    parameter int          RECOVER_FRAMES = 8,
    parameter logic [15:0] SPRITE_WORDS   = game_pkg::SPRITE_WORDS,
    parameter logic [15:0] ANIM_BASE      = 16'd0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        shot,
    input  logic        enable,
    output logic        hit,
    output logic        busy,
    output logic        camo_break,
    output logic [15:0] anim_offset,
    output logic [7:0]  attack_count
);
    localparam logic [3:0] WINDUP_LD  = 4'(WINDUP_FRAMES - 1);
    localparam logic [3:0] STRIKE_LD  = 4'(STRIKE_FRAMES - 1);
    localparam logic [3:0] RECOVER_LD = 4'(RECOVER_FRAMES - 1);
`ifdef ATTACK_BUFFER_EN
    localparam logic BUFFER_EN = 1'b1;
`else
    localparam logic BUFFER_EN = 1'b0;
`endif

    attack_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d, shot_q, shot_d;
    logic        hit_q, hit_d, busy_q, busy_d, camo_q, camo_d;
    logic [15:0] anim_q, anim_d;
    logic [7:0]  count_q, count_d;
    logic        tick, press, can_buffer;

    frame_tick_gen u_tick (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign press      = shot & ~shot_q;
    assign can_buffer = BUFFER_EN && (state_q == RECOVER);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shot_d  = shot;
        pend_d  = pend_q | (press & enable & ((state_q == IDLE) | can_buffer));
        if (tick) begin
            if (state_q == IDLE) begin
                if (pend_q) begin
                    state_d = WINDUP;
                    cnt_d   = WINDUP_LD;
                    pend_d  = 1'b0;
                end
            end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else if (state_q == WINDUP) begin
                state_d = STRIKE;
                cnt_d   = STRIKE_LD;
            end else if (state_q == STRIKE) begin
                state_d = RECOVER;
                cnt_d   = RECOVER_LD;
            end else if (can_buffer && pend_q) begin
                state_d = WINDUP;
                cnt_d   = WINDUP_LD;
                pend_d  = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end
        // Losing enable overrides whatever the tick would have done.
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            pend_d  = 1'b0;
        end
        hit_d   = state_d == STRIKE;
        busy_d  = state_d != IDLE;
        camo_d  = (state_d == STRIKE) && (state_q != STRIKE);
        count_d = count_q + {7'd0, camo_d};
        anim_d  = anim_offset_of(state_d, ANIM_BASE, SPRITE_WORDS);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            shot_q  <= 1'b0;
            hit_q   <= 1'b0;
            busy_q  <= 1'b0;
            camo_q  <= 1'b0;
            anim_q  <= ANIM_BASE;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            shot_q  <= shot_d;
            hit_q   <= hit_d;
            busy_q  <= busy_d;
            camo_q  <= camo_d;
            anim_q  <= anim_d;
            count_q <= count_d;
        end
    end

    assign hit          = hit_q;
    assign busy         = busy_q;
    assign camo_break   = camo_q;
    assign anim_offset  = anim_q;
    assign attack_count = count_q;
endmodule

// File: tb/tb_melee_attack_ctrl.sv
// tb_melee_attack_ctrl: directed scenarios checked against a tick-counting model of the attack timeline.
module tb_melee_attack_ctrl;
    localparam int W = 4, S = 3, R = 8, TOT = W + S + R;
    localparam int WORDS = 3240;
`ifdef ATTACK_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        Clk = 0, Reset = 0, frame_clk = 0, shot = 0, enable = 1;
    logic        hit, busy, camo_break;
    logic [15:0] anim_offset;
    logic [7:0]  attack_count;

    melee_attack_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .shot         (shot),
        .enable       (enable),
        .hit          (hit),
        .busy         (busy),
        .camo_break   (camo_break),
        .anim_offset  (anim_offset),
        .attack_count (attack_count)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0, n_err = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int fper = 20, fcyc = 0;
    always @(negedge Clk) begin
        fcyc = (fcyc + 1) % fper;
        frame_clk = fcyc < fper / 2;
    end

    // Model: an attack is a count of ticks elapsed since wind-up began; phase follows from that count.
    bit       m_act, m_pend, m_fc, m_tick, m_shp, m_camo, np, prs;
    int       m_el, ph0, m_ph;
    bit [7:0] m_cnt;
    function automatic int phase_of(bit act, int el);
        return !act ? 0 : (el < W) ? 1 : (el < W + S) ? 2 : 3;
    endfunction
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_act = 0; m_pend = 0; m_fc = 0; m_tick = 0; m_shp = 0; m_camo = 0; m_el = 0; m_ph = 0; m_cnt = 0;
        end else begin
            ph0 = phase_of(m_act, m_el);
            prs = shot && !m_shp;
            np  = m_pend || (prs && enable && (ph0 == 0 || (BUF && ph0 == 3)));
            if (!enable) begin
                m_act = 0;
                np = 0;
            end else if (m_tick) begin
                if (!m_act) begin
                    if (m_pend) begin m_act = 1; m_el = 0; np = 0; end
                end else begin
                    m_el++;
                    if (m_el == TOT) begin
                        if (BUF && m_pend) begin m_el = 0; np = 0; end
                        else m_act = 0;
                    end
                end
            end
            m_pend = np;
            m_ph   = phase_of(m_act, m_el);
            m_camo = (m_ph == 2) && (ph0 != 2);
            if (m_camo) m_cnt++;
            m_tick = frame_clk && !m_fc;
            m_fc   = frame_clk;
            m_shp  = shot;
        end
    end

    always @(negedge Clk) begin
        if (Reset) begin
            chk("model_hit", hit, m_ph == 2);
            chk("model_busy", busy, m_ph != 0);
            chk("model_camo", camo_break, m_camo);
            chk("model_anim", anim_offset, (m_ph == 0) ? 0 : (m_ph == 2) ? 2 * WORDS : WORDS);
            chk("model_count", attack_count, m_cnt);
        end
    end

    // Scenario monitors, cleared just after a rising edge.
    int cyc = 0, n_hit, n_busy, n_camo, n_bfall, busy_rise, hit_rise, n_log;
    logic [15:0] alog [8];
    logic hit_p = 0, busy_p = 0;
    logic [15:0] anim_p = 0;
    always @(negedge Clk) begin
        cyc++;
        if (hit) n_hit++;
        if (busy) n_busy++;
        if (camo_break) n_camo++;
        if (busy && !busy_p) busy_rise = cyc;
        if (hit && !hit_p) hit_rise = cyc;
        if (busy_p && !busy) n_bfall++;
        if (anim_offset != anim_p && n_log < 8) begin alog[n_log] = anim_offset; n_log++; end
        hit_p = hit; busy_p = busy; anim_p = anim_offset;
    end
    task automatic clr();
        @(posedge Clk);
        n_hit = 0; n_busy = 0; n_camo = 0; n_bfall = 0; busy_rise = 0; hit_rise = 0; n_log = 0;
    endtask

    task automatic pulse();
        @(negedge Clk) shot = 1;
        @(negedge Clk) shot = 0;
    endtask
    task automatic wait_hit(input logic v, input int budget);
        for (int n = 0; n < budget && hit !== v; n++) @(negedge Clk);
        chk("wait_hit", hit, v);
    endtask
    task automatic wait_busy(input logic v, input int budget);
        for (int n = 0; n < budget && busy !== v; n++) @(negedge Clk);
        chk("wait_busy", busy, v);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_hit", hit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_camo", camo_break, 0);
        chk("rst_anim", anim_offset, 0);
        chk("rst_count", attack_count, 0);
        @(negedge Clk) #2 Reset = 1;

        clr();
        pulse();
        repeat (400) @(negedge Clk);
        chk("basic_hit_cycles", n_hit, 60);
        chk("basic_busy_cycles", n_busy, 300);
        chk("basic_camo", n_camo, 1);
        chk("basic_count", attack_count, 1);
        chk("basic_windup_len", hit_rise - busy_rise, 80);
        chk("basic_anim_n", n_log, 4);
        chk("basic_anim0", alog[0], 3240);
        chk("basic_anim1", alog[1], 6480);
        chk("basic_anim2", alog[2], 3240);
        chk("basic_anim3", alog[3], 0);

        clr();
        @(negedge Clk) shot = 1;
        repeat (400) @(negedge Clk);
        shot = 0;
        repeat (100) @(negedge Clk);
        chk("held_camo", n_camo, 1);
        chk("held_count", attack_count, 2);

        clr();
        pulse();
        wait_hit(1, 200);
        @(negedge Clk) enable = 0;
        @(posedge Clk) #1;
        chk("abort_hit", hit, 0);
        chk("abort_busy", busy, 0);
        chk("abort_anim", anim_offset, 0);
        pulse();
        repeat (60) @(negedge Clk);
        enable = 1;
        clr();
        repeat (60) @(negedge Clk);
        chk("abort_no_attack", n_busy, 0);
        chk("abort_count", attack_count, 3);

        clr();
        pulse();
        wait_hit(1, 200);
        wait_hit(0, 100);
        repeat (40) @(negedge Clk);
        chk("recover_busy", busy, 1);
        pulse();
        repeat (500) @(negedge Clk);
        chk("recover_camo", n_camo, BUF ? 2 : 1);
        chk("recover_busy_cycles", n_busy, BUF ? 600 : 300);
        chk("recover_busy_fall", n_bfall, 1);
        chk("recover_count", attack_count, BUF ? 5 : 4);

        pulse();
        wait_hit(1, 200);
        @(negedge Clk) #2 Reset = 0;
        #1;
        chk("mid_rst_hit", hit, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_anim", anim_offset, 0);
        chk("mid_rst_count", attack_count, 0);
        repeat (3) @(posedge Clk);
        @(negedge Clk) #2 Reset = 1;

        fper = 4;
        repeat (8) @(negedge Clk);
        clr();
        for (int i = 0; i < 256; i++) begin
            pulse();
            wait_busy(1, 50);
            wait_busy(0, 200);
            if (i == 254) chk("count_255", attack_count, 255);
        end
        repeat (4) @(negedge Clk);
        chk("wrap_camo", n_camo, 256);
        chk("wrap_count", attack_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/melee_attack_ctrl.md
Name: melee_attack_ctrl

Overview:
- Player-side attack sequencer that drives the `hit` input consumed by every enemy block.
- Converts the raw `shot` key into a frame-timed attack: wind-up, strike window, recovery.
- Supplies the player sprite with an animation-frame offset and tells the camo logic when an attack breaks cover.
- Sits between the keycode decoder and the enemy/collision stage; all timing is in frames of `frame_clk`.

Parameters:
- WINDUP_FRAMES, 4, frames spent in WINDUP before the strike (legal 1..15)
- STRIKE_FRAMES, 3, frames `hit` is held high (legal 1..15)
- RECOVER_FRAMES, 8, frames of cooldown after the strike (legal 1..15)
- SPRITE_WORDS, 16'd3240, ROM words per player sprite frame (60x54)
- ANIM_BASE, 16'd0, ROM address of the idle player frame

Ports:
- Clk  in  1  50 MHz system clock
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  ~60 Hz frame clock
- shot  in  1  attack key, level, Clk domain
- enable  in  1  player alive and game running; low aborts any attack
- hit  out  1  strike window active
- busy  out  1  FSM not in IDLE
- camo_break  out  1  one-Clk pulse on entering STRIKE
- anim_offset  out  16  added to the player sprite address
- attack_count  out  8  strikes issued, wraps modulo 256

Behaviour:
- Reset (Reset=0, async): state=IDLE, counter=0, pend=0, hit=0, busy=0, camo_break=0, anim_offset=ANIM_BASE, attack_count=0, edge regs=0.
- Frame tick:
  - fc_d <= frame_clk; tick <= frame_clk & ~fc_d, both registered.
  - tick is high exactly one Clk per frame_clk rising edge.
- Press detect:
  - shot_d <= shot; press = shot & ~shot_d.
  - press sets pend only when state==IDLE and enable==1; presses in any other state are dropped.
  - Holding shot never re-triggers.
- FSM states: IDLE, WINDUP, STRIKE, RECOVER. Transitions occur only on Clk cycles with tick=1, except enable abort.
  - IDLE: if tick & pend -> WINDUP, counter=WINDUP_FRAMES-1, pend cleared.
  - WINDUP/STRIKE/RECOVER: on tick, if counter!=0 then counter-1; else go to the next state, loading its FRAMES-1.
  - Order is WINDUP->STRIKE->RECOVER->IDLE.
  - Net effect: each phase lasts exactly N ticks.
- Enable abort: enable==0 in any state -> next Clk state=IDLE, pend=0, counter=0, hit=0. This is independent of tick, and enable wins over a simultaneous tick transition.
- Outputs:
  - hit = (state==STRIKE), from the state register, so it rises one Clk after the transition tick.
  - busy = (state!=IDLE).
  - camo_break is registered and high for the single Clk in which state becomes STRIKE.
  - attack_count increments in that same cycle.
- anim_offset: IDLE=ANIM_BASE, WINDUP=ANIM_BASE+SPRITE_WORDS, STRIKE=ANIM_BASE+2*SPRITE_WORDS, RECOVER=ANIM_BASE+SPRITE_WORDS. Width is 16 bits, unsigned, no overflow check (the integrator guarantees fit).
- Latency:
  - press at Clk t -> pend at t+1 -> WINDUP at the first tick after t+1.
  - Total attack length = WINDUP+STRIKE+RECOVER ticks.
- Simultaneous press and tick in IDLE: the press is latched; the attack starts on the following tick.
- attack_count wraps from 255 to 0.

Optional Feature:
- ATTACK_BUFFER_EN defined:
  - A press during RECOVER (enable=1) sets pend.
  - When RECOVER expires with pend=1, the FSM goes directly RECOVER->WINDUP on that tick (no IDLE frame) and clears pend.
  - Presses in WINDUP/STRIKE are still dropped.
  - enable abort still clears pend.
- Undefined: presses outside IDLE are ignored as described above.

Decomposition:
- Shared package game_pkg:
  - attack_state_t enum (IDLE, WINDUP, STRIKE, RECOVER).
  - SPRITE_WORDS and sprite-size constants, shared with the enemy blocks.
- Sub-module frame_tick_gen (frame_clk in, tick out; edge detect with async active-low reset). It is natural to reuse it across all enemy/player blocks.
- FSM, counter and output logic stay in melee_attack_ctrl.

Test Plan:
- Reset mid-STRIKE (drop Reset for 3 Clk) -> hit=0, busy=0, anim_offset=0, attack_count=0 immediately, asynchronously.
- Basic attack, defaults:
  - One-Clk shot pulse, ticks every 20 Clk (fast sim).
  - hit high for exactly 3 ticks, starting 4 ticks after the first tick post-press.
  - busy high for 15 ticks; attack_count=1; one camo_break pulse; anim_offset sequence 3240, 6480, 3240, 0.
- shot held high 400 Clk -> exactly one attack (attack_count=1).
- enable dropped during STRIKE -> next Clk hit=0, state IDLE. A shot press while enable=0 never starts an attack.
- Press during RECOVER:
  - Macro off -> no second attack, attack_count=1.
  - ATTACK_BUFFER_EN on -> WINDUP follows RECOVER with zero IDLE ticks, attack_count=2.
- 256 back-to-back attacks -> attack_count reads 0 after the 256th camo_break.
